// File: rtl/reg_share_arb_pkg.sv
// rtl/reg_share_arb_pkg.sv - shared types and constants for the shared-register arbiter
package reg_share_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int N_REQ        = 4;
  localparam int CNT_W        = 4;
  localparam int LOCK_RUN_MAX = 4;
  localparam int RUN_W        = 2;

endpackage

// File: rtl/reg_share_arb_rr_pick.sv
// rtl/reg_share_arb_rr_pick.sv - combinational round-robin picker starting after the last served index
module rr_pick
  import reg_share_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [1:0]       ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [1:0]       idx_o
);

  logic [1:0] cand;
  logic       found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = ptr_i + i[1:0];
      if (!found && req_i[cand]) begin
        found        = 1'b1;
        idx_o        = cand;
        gnt_o[cand]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_share_arb.sv
// rtl/reg_share_arb.sv - four-requester arbiter owning a shared register, falling-edge clocked
// Optional REG_SHARE_ARB_LOCK_EN adds LOCK for bounded back-to-back re-grants.
module reg_share_arb
  import reg_share_arb_pkg::*;
#(
  parameter int W        = 8,
  parameter int HOLD_CYC = 2
) (
  input  logic               C,
  input  logic               CLR_N,
  input  logic [N_REQ-1:0]   REQ,
  input  logic [N_REQ*W-1:0] DIN,
`ifdef REG_SHARE_ARB_LOCK_EN
  input  logic [N_REQ-1:0]   LOCK,
`endif
  output logic [N_REQ-1:0]   GNT,
  output logic [N_REQ-1:0]   ACK,
  output logic [W-1:0]       Q,
  output logic               BUSY
);

  state_t           state_q;
  logic [N_REQ-1:0] gnt_q;
  logic [N_REQ-1:0] ack_q;
  logic [W-1:0]     q_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       ptr_q;
  logic [1:0]       idx_q;
`ifdef REG_SHARE_ARB_LOCK_EN
  logic [RUN_W-1:0] run_q;
`endif

  logic [N_REQ-1:0] win_gnt;
  logic [1:0]       win_idx;
  logic [W-1:0]     q_d;

  rr_pick u_pick (
    .req_i (REQ),
    .ptr_i (ptr_q),
    .gnt_o (win_gnt),
    .idx_o (win_idx)
  );

  assign q_d = DIN[idx_q*W +: W];

  always_ff @(negedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ack_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      ptr_q   <= 2'd3;
      idx_q   <= '0;
`ifdef REG_SHARE_ARB_LOCK_EN
      run_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= '0;
          if (|REQ) begin
            state_q <= GRANT;
            gnt_q   <= win_gnt;
            idx_q   <= win_idx;
          end else begin
            gnt_q <= '0;
          end
        end
        GRANT: begin
          state_q <= HOLD;
          q_q     <= q_d;
          ack_q   <= gnt_q;
          cnt_q   <= CNT_W'(HOLD_CYC - 1);
        end
        HOLD: begin
          ack_q <= '0;
          if (cnt_q == '0) begin
`ifdef REG_SHARE_ARB_LOCK_EN
            // run_q counts re-grants already given, so the limit caps the whole run
            if (LOCK[idx_q] && run_q != RUN_W'(LOCK_RUN_MAX - 1)) begin
              state_q <= GRANT;
              run_q   <= run_q + 1'b1;
            end else begin
              state_q <= IDLE;
              gnt_q   <= '0;
              ptr_q   <= idx_q;
              run_q   <= '0;
            end
`else
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= idx_q;
`endif
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          ack_q   <= '0;
        end
      endcase
    end
  end

  assign GNT  = gnt_q;
  assign ACK  = ack_q;
  assign Q    = q_q;
  assign BUSY = (state_q != IDLE);

endmodule

// File: doc/reg_share_arb.md
REG_SHARE_ARB -- requirements
Module: reg_share_arb

Interface
REQ-001 SHALL have parameter W, default 8: width of the shared register and of each requester data lane.
REQ-002 SHALL have parameter HOLD_CYC, default 2, legal range 1..15: cycles the shared register stays owned after a load.
REQ-003 SHALL have port C, input, 1 bit: the single clock; all sequential logic updates on its falling edge.
REQ-004 SHALL have port CLR_N, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port REQ, input, 4 bits: one request per requester, level-sensitive.
REQ-006 SHALL have port DIN, input, 4*W bits: requester i data is DIN[i*W +: W].
REQ-007 SHALL have port GNT, output, 4 bits: one-hot grant, registered.
REQ-008 SHALL have port ACK, output, 4 bits: one-cycle load-done pulse to the granted requester, registered.
REQ-009 SHALL have port Q, output, W bits: the shared register contents.
REQ-010 SHALL have port BUSY, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-011 SHALL implement the FSM states IDLE, GRANT and HOLD.
REQ-012 IDLE: with any REQ bit high at a falling edge, SHALL go to GRANT and set GNT to the winner; with REQ=0, SHALL stay in IDLE with GNT=0.
REQ-013 The winner SHALL be chosen round-robin: search starts at (PTR+1) mod 4 and wraps; PTR holds the last served index.
REQ-014 GRANT SHALL last exactly 1 cycle; on the edge leaving it, Q SHALL load DIN lane of the granted requester, and the HOLD counter SHALL load HOLD_CYC-1.
REQ-015 ACK[granted] SHALL be high for exactly the first HOLD cycle; all other ACK bits SHALL stay 0.
REQ-016 HOLD SHALL last HOLD_CYC cycles with GNT held; after the last one, the FSM SHALL return to IDLE, clear GNT and set PTR to the served index.
REQ-017 Latency: REQ seen in IDLE at edge k gives GNT valid after edge k, and Q plus ACK valid after edge k+1.
REQ-018 Deasserting REQ during GRANT or HOLD SHALL NOT abort the cycle: the load and the full HOLD still complete.
REQ-019 Back-to-back grants SHALL pass through at least one IDLE cycle.
REQ-020 Q SHALL change only on the edge leaving GRANT.
REQ-021 Simultaneous requests SHALL produce exactly one GNT bit, and no requester is starved for more than 3 grants.

Reset
REQ-022 CLR_N low SHALL at once (asynchronously) force: state=IDLE, GNT=0, ACK=0, Q=0, HOLD counter=0, PTR=3 (requester 0 gets first priority).
REQ-023 A reset during GRANT or HOLD SHALL abandon the transaction, with no ACK issued afterwards.
REQ-024 Release of CLR_N SHALL take effect at the next falling edge of C.

Configuration
REQ-025 Macro REG_SHARE_ARB_LOCK_EN: when defined, SHALL add input LOCK (4 bits).
- If LOCK[granted] is high in the last HOLD cycle, the FSM SHALL go straight to GRANT for the same requester.
- PTR SHALL NOT advance on such a re-grant.
- At most 4 consecutive grants to one requester are allowed; after that, a forced IDLE cycle and a normal PTR update SHALL follow.
REQ-026 When REG_SHARE_ARB_LOCK_EN is undefined, LOCK SHALL be absent and behaviour SHALL equal LOCK=0.

Structure
REQ-027 Package reg_share_arb_pkg SHALL hold:
- the state enum (IDLE, GRANT, HOLD);
- the constant N_REQ=4;
- the HOLD counter width (4);
- the lock-run limit (4).
REQ-028 Sub-module rr_pick SHALL be the combinational round-robin picker: inputs REQ and PTR; outputs one-hot winner and index.
REQ-029 The shared register SHALL be inline; no other sub-modules.

Verification
REQ-030 Reset then REQ=0001, DIN0=8'hA5, HOLD_CYC=2 -> GNT=0001 one edge later; after the next edge Q=8'hA5 and ACK=0001 for 1 cycle; BUSY for 3 cycles; then IDLE.
REQ-031 REQ=1111 held constant -> grant order 0,1,2,3,0; each grant separated by one IDLE cycle; Q follows each lane's DIN.
REQ-032 REQ=0100 dropped to 0 during GRANT -> Q still loads DIN2, ACK=0100 pulses, HOLD completes.
REQ-033 CLR_N pulled low mid-HOLD -> GNT, ACK and Q all 0 at once; after release with REQ=1000 -> requester 3 granted normally.
REQ-034 With REG_SHARE_ARB_LOCK_EN, REQ=0011 and LOCK=0001 -> requester 0 granted 4 times in a row, then a forced IDLE cycle, then requester 1 granted.
REQ-035 HOLD_CYC=1 with REQ=0010 constant -> repeating GRANT, HOLD, IDLE cycle of period 3; ACK pulses every 3 cycles.
